// File: rtl/cover_toggle_collector.sv
// Coverage collector: latches the first hit of each cover point in a sticky bitmap
// and streams each newly covered point once, as a global index, over valid/ready.
module cover_toggle_collector #(
    parameter int          WIDTH       = 64,
    parameter logic [63:0] COVER_INDEX = 64'd0,
    parameter int          MODE        = 0,
    parameter int          CNT_W       = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_index,
    output logic [CNT_W-1:0] covered_count,
    output logic             all_covered
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] prev;
    logic             prev_ok;
    logic [WIDTH-1:0] sticky;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] new_hits;
    logic [WIDTH-1:0] low_onehot;
    logic [WIDTH-1:0] pending_next;
    logic [IDX_W-1:0] low_idx;
    logic [CNT_W-1:0] new_count;
    logic             fire;
    logic             load;

    // Toggle mode ignores the very first sample: it only sets the baseline.
    assign raw      = (MODE == 1) ? ((valid ^ prev) & {WIDTH{prev_ok}}) : valid;
    assign new_hits = raw & ~sticky & {WIDTH{enable & ~clear}};

    assign out_valid   = (state == SEND);
    assign fire        = out_valid & out_ready;
    assign load        = (|pending) & ~clear & ((state == IDLE) | fire);
    assign low_onehot  = pending & (~pending + WIDTH'(1));
    assign all_covered = (covered_count == CNT_W'(WIDTH));

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        low_idx   = '0;
        new_count = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending[i]) low_idx = IDX_W'(i);
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (new_hits[i]) new_count = new_count + CNT_W'(1);
        end
    end

    // The bit handed to the output is dropped before this cycle's new hits are merged.
    assign pending_next = clear ? '0
                        : ((pending & ~(load ? low_onehot : '0)) | new_hits);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            prev          <= '0;
            prev_ok       <= 1'b0;
            sticky        <= '0;
            pending       <= '0;
            out_index     <= '0;
            covered_count <= '0;
        end else begin
            prev          <= valid;
            prev_ok       <= 1'b1;
            sticky        <= clear ? '0 : (sticky | new_hits);
            pending       <= pending_next;
            covered_count <= clear ? '0 : (covered_count + new_count);
            if (load) begin
                state     <= SEND;
                out_index <= COVER_INDEX + 64'(low_idx);
            end else if (fire) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: doc/cover_toggle_collector.md
# cover_toggle_collector

Parametrised toggle/level coverage collector for the formal/fuzz coverage harness. It samples a WIDTH-bit vector of cover points every cycle and records each point's first hit in a sticky bitmap. Each newly covered point is emitted exactly once, as a global cover index, over a valid/ready stream. The block replaces per-cycle, per-bit reporting with deduplicated, back-pressurable reporting. It also keeps a running covered count for the harness.

## Interface
- WIDTH, 64: number of cover points sampled; 1..1024.
- COVER_INDEX, 0: global index of point 0; point i reports COVER_INDEX+i.
- MODE, 0: 0 = level (point hit when its bit is 1); 1 = toggle (point hit when its bit differs from the previous sampled value).
- CNT_W, $clog2(WIDTH+1): width of covered_count.

- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  sampling enable; when 0, valid is ignored for hit detection.
- clear  in  1  synchronous clear of coverage state (sticky, pending, count).
- valid  in  WIDTH  cover point vector.
- out_valid  out  1  cover index available.
- out_ready  in  1  consumer accepts out_index when out_valid=1.
- out_index  out  64  global cover index (COVER_INDEX+i), zero-extended.
- covered_count  out  CNT_W  number of sticky bits set.
- all_covered  out  1  covered_count == WIDTH.

## Operation
- Registers: prev[WIDTH], prev_ok, sticky[WIDTH], pending[WIDTH], out_index, out_valid (FSM state), covered_count.
- Raw hit: MODE 0: valid; MODE 1: (valid ^ prev) & {WIDTH{prev_ok}}.
- prev <= valid and prev_ok <= 1 every cycle, regardless of enable or clear. The first sample after reset only establishes the baseline and produces no toggle hits.
- new = raw & ~sticky & {WIDTH{enable}} & {WIDTH{~clear}}.
- sticky <= sticky | new; pending <= pending | new; covered_count <= covered_count + popcount(new).
- On clear: sticky, pending and covered_count are zeroed, and that cycle's hits are discarded. An index already presented on out_index stays valid until accepted.
- Drain FSM:
  - IDLE (out_valid=0): if pending != 0, go to SEND. Load out_index = COVER_INDEX + lowest set bit of pending, and clear that pending bit.
  - SEND (out_valid=1): out_index is held stable until fire (out_valid & out_ready).
    - On fire with other pending bits set, load the next lowest bit and stay in SEND (back-to-back, one index per cycle).
    - On fire with pending empty, go to IDLE.
  - The pending bit removed on load and a new bit set in the same cycle combine: clear, then OR in new.
- Each point is emitted at most once between clears or resets. Emission order is lowest index first among the bits pending at load time.
- COVER_INDEX+i is computed in 64 bits and wraps modulo 2^64.

## Timing
- Reset (async assert, sync release): prev=0, prev_ok=0, sticky=0, pending=0, out_valid=0, out_index=0, covered_count=0, all_covered=0. Assertion mid-transfer drops out_valid immediately, and the index in flight is lost.
- Hit latency: bit sampled at edge N sets sticky and covered_count after edge N. The earliest out_valid is after edge N+1.
- covered_count and all_covered are registered and update one edge after the sampling edge.
- With out_ready held at 1, K simultaneous new hits drain in K consecutive cycles.
- Under backpressure, pending accumulates without loss. Pending cannot overflow because it has WIDTH bits.
- Back-to-back hits of an already-sticky point produce nothing.
- Clear asserted in the same cycle as a fire: the fire completes, and pending is empty afterwards, so the FSM goes to IDLE.

## Test plan
- Level mode, WIDTH=64, COVER_INDEX=100. Pulse valid[5] for 1 cycle, out_ready=1.
  -> out_valid for exactly 1 cycle, 2 edges after the sample, out_index=105. covered_count=1 after 1 edge.
- Set valid bits 3, 0 and 63 in one cycle with out_ready=1.
  -> out_index 100, 103, 163 on consecutive cycles. covered_count=3.
  -> Repeating the same stimulus yields no further out_valid.
- Backpressure: hits on bits 7 and 9, out_ready=0 for 10 cycles, then 1.
  -> out_index=107 held stable for the whole stall, then 109 on the next cycle.
- MODE=1: valid=0x1 held from reset release, then 0x3, then 0x3.
  -> no hit on the first sample, a single hit with index COVER_INDEX+1, nothing further.
- Hit all 64 bits, then pulse clear together with valid[2].
  -> all_covered=1 before the clear. After the clear: covered_count=0 and bit 2 is not recorded. A later hit on bit 2 re-emits its index.
- Assert reset while out_valid=1 with 4 pending.
  -> out_valid drops with no clock edge. After release, all outputs are 0 and no stale index is ever emitted.
